// File: rtl/arith_pkg.sv
// Shared encodings for the inc/dec arithmetic blocks.
package arith_pkg;
   typedef enum logic {
      MODE_INC = 1'b0,
      MODE_DEC = 1'b1
   } mode_e;

   typedef enum logic {
      SAT_WRAP  = 1'b0,
      SAT_CLAMP = 1'b1
   } sat_e;
endpackage

// File: rtl/inc_dec_core.sv
// Combinational step-sized increment/decrement over 0..MAX_VAL with wrap or clamp.
module inc_dec_core
   import arith_pkg::*;
#(
   parameter int unsigned N       = 4,
   parameter int unsigned MAX_VAL = 2**N - 1
) (
   input  logic [N-1:0] cur,
   input  logic [N-1:0] k,
   input  logic         mode,
   input  logic         sat,
   output logic [N-1:0] nxt,
   output logic         ovf_c,
   output logic         unf_c
);
   localparam int unsigned W = N + 1;
   localparam logic [N:0] MAX_W = W'(MAX_VAL);
   localparam logic [N:0] MOD_W = W'(MAX_VAL + 1);

   logic [N:0] cur_w;
   logic [N:0] k_w;
   logic [N:0] res_w;

   assign cur_w = {1'b0, cur};
   assign k_w   = {1'b0, k};

   // One extra bit keeps the sum and the borrow-corrected difference exact.
   always_comb begin
      res_w = cur_w;
      ovf_c = 1'b0;
      unf_c = 1'b0;
      if (mode == MODE_INC) begin
         res_w = cur_w + k_w;
         if (res_w > MAX_W) begin
            ovf_c = 1'b1;
            res_w = (sat == SAT_CLAMP) ? MAX_W : res_w - MOD_W;
         end
      end else begin
         if (cur_w >= k_w) begin
            res_w = cur_w - k_w;
         end else begin
            unf_c = 1'b1;
            res_w = (sat == SAT_CLAMP) ? '0 : cur_w + MOD_W - k_w;
         end
      end
   end

   assign nxt = res_w[N-1:0];
endmodule

// File: rtl/inc_dec_counter.sv
// Registered up/down counter with runtime step, wrap/saturate, parallel load and status flags.
module inc_dec_counter
   import arith_pkg::*;
#(
   parameter int unsigned N       = 4,
   parameter int unsigned MAX_VAL = 2**N - 1,
   parameter int unsigned S       = N
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic         mode,
   input  logic         sat,
   input  logic [S-1:0] step,
   input  logic         load,
   input  logic [N-1:0] load_val,
   output logic [N-1:0] count,
   output logic         ovf,
   output logic         unf,
   output logic         at_max,
   output logic         at_zero
);
   localparam int unsigned CW = ((S > N) ? S : N) + 1;
   localparam logic [CW-1:0] MAX_CW = CW'(MAX_VAL);
   localparam logic [N-1:0]  MAX_N  = N'(MAX_VAL);

   logic [CW-1:0] step_w;
   logic [N-1:0]  k;
   logic [N-1:0]  load_clamped;
   logic [N-1:0]  nxt;
   logic          ovf_c, unf_c;
   logic [N-1:0]  count_d, count_q;
   logic          ovf_d, ovf_q;
   logic          unf_d, unf_q;

   assign step_w       = CW'(step);
   assign k            = (step_w > MAX_CW) ? MAX_N : step_w[N-1:0];
   assign load_clamped = (load_val > MAX_N) ? MAX_N : load_val;

   inc_dec_core #(
      .N       (N),
      .MAX_VAL (MAX_VAL)
   ) u_core (
      .cur   (count_q),
      .k     (k),
      .mode  (mode),
      .sat   (sat),
      .nxt   (nxt),
      .ovf_c (ovf_c),
      .unf_c (unf_c)
   );

   always_comb begin
      count_d = count_q;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
      if (load) begin
         count_d = load_clamped;
      end else if (en) begin
         count_d = nxt;
         ovf_d   = ovf_c;
         unf_d   = unf_c;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   assign count   = count_q;
   assign ovf     = ovf_q;
   assign unf     = unf_q;
   assign at_max  = (count_q == MAX_N);
   assign at_zero = (count_q == '0);
endmodule

// File: tb/tb_inc_dec_counter.sv
// Scoreboard bench: two counters (MAX_VAL=9 and default 15) share stimulus and are checked against an integer model.
module tb_inc_dec_counter;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic       mode = 1'b0;
   logic       sat = 1'b0;
   logic [3:0] step = '0;
   logic       load = 1'b0;
   logic [3:0] load_val = '0;

   logic [3:0] count_a, count_b;
   logic       ovf_a, unf_a, at_max_a, at_zero_a;
   logic       ovf_b, unf_b, at_max_b, at_zero_b;

   always #5 clk = ~clk;

   inc_dec_counter #(.N(4), .MAX_VAL(9), .S(4)) dut_a (
      .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sat(sat), .step(step),
      .load(load), .load_val(load_val), .count(count_a), .ovf(ovf_a), .unf(unf_a),
      .at_max(at_max_a), .at_zero(at_zero_a)
   );

   inc_dec_counter #(.N(4)) dut_b (
      .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sat(sat), .step(step),
      .load(load), .load_val(load_val), .count(count_b), .ovf(ovf_b), .unf(unf_b),
      .at_max(at_max_b), .at_zero(at_zero_b)
   );

   typedef struct {
      int cnt_a;
      bit ovf_a;
      bit unf_a;
      int cnt_b;
      bit ovf_b;
      bit unf_b;
   } exp_t;

   exp_t exp_q[$];
   int   m_cnt_a = 0;
   int   m_cnt_b = 0;
   int   n_cmp = 0;
   int   n_err = 0;

   // Counter behaviour in plain integer arithmetic over 0..maxv.
   function automatic void ref_step(input int maxv, input int cur, input bit r, input bit ld,
                                    input int lv, input bit e, input bit md, input bit st,
                                    input int stp, output int nxt, output bit o, output bit u);
      int k;
      int t;
      k   = (stp > maxv) ? maxv : stp;
      nxt = cur;
      o   = 1'b0;
      u   = 1'b0;
      if (!r) begin
         nxt = 0;
      end else if (ld) begin
         nxt = (lv > maxv) ? maxv : lv;
      end else if (e) begin
         if (!md) begin
            t = cur + k;
            if (t > maxv) begin
               o   = 1'b1;
               nxt = st ? maxv : t - (maxv + 1);
            end else begin
               nxt = t;
            end
         end else begin
            if (cur < k) begin
               u   = 1'b1;
               nxt = st ? 0 : cur + (maxv + 1) - k;
            end else begin
               nxt = cur - k;
            end
         end
      end
   endfunction

   task automatic chk(input string nm, input int act, input int expv);
      n_cmp++;
      if (act != expv) begin
         n_err++;
         $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, expv);
      end
   endtask

   task automatic drive(input bit r, input bit ld, input int lv, input bit e,
                        input bit md, input bit st, input int stp);
      exp_t x;
      int   na, nb;
      bit   oa, ua, ob, ub;
      @(negedge clk);
      rst_n    = r;
      load     = ld;
      load_val = lv[3:0];
      en       = e;
      mode     = md;
      sat      = st;
      step     = stp[3:0];
      @(posedge clk);
      ref_step(9,  m_cnt_a, r, ld, lv, e, md, st, stp, na, oa, ua);
      ref_step(15, m_cnt_b, r, ld, lv, e, md, st, stp, nb, ob, ub);
      m_cnt_a = na;
      m_cnt_b = nb;
      x.cnt_a = na; x.ovf_a = oa; x.unf_a = ua;
      x.cnt_b = nb; x.ovf_b = ob; x.unf_b = ub;
      exp_q.push_back(x);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("count_a",   int'(count_a),   e.cnt_a);
            chk("ovf_a",     int'(ovf_a),     int'(e.ovf_a));
            chk("unf_a",     int'(unf_a),     int'(e.unf_a));
            chk("at_max_a",  int'(at_max_a),  (e.cnt_a == 9)  ? 1 : 0);
            chk("at_zero_a", int'(at_zero_a), (e.cnt_a == 0)  ? 1 : 0);
            chk("count_b",   int'(count_b),   e.cnt_b);
            chk("ovf_b",     int'(ovf_b),     int'(e.ovf_b));
            chk("unf_b",     int'(unf_b),     int'(e.unf_b));
            chk("at_max_b",  int'(at_max_b),  (e.cnt_b == 15) ? 1 : 0);
            chk("at_zero_b", int'(at_zero_b), (e.cnt_b == 0)  ? 1 : 0);
         end
      end
   end

   initial begin : stimulus
      int wait_cycles;
      // reset, then wrap increment by 1
      drive(0, 0, 0, 0, 0, 0, 0);
      repeat (10) drive(1, 0, 0, 1, 0, 0, 1);
      // wrap decrement with step 3 from 2
      drive(1, 1, 2, 0, 0, 0, 0);
      drive(1, 0, 0, 1, 1, 0, 3);
      drive(1, 0, 0, 1, 1, 0, 3);
      // saturate at both ends
      drive(1, 1, 7, 0, 0, 0, 0);
      drive(1, 0, 0, 1, 0, 1, 4);
      drive(1, 0, 0, 1, 0, 1, 4);
      drive(1, 1, 3, 0, 0, 0, 0);
      drive(1, 0, 0, 1, 1, 1, 4);
      // load priority and clamp, then hold
      drive(1, 1, 15, 1, 0, 0, 1);
      drive(1, 0, 0, 0, 0, 0, 1);
      // step zero and oversize step
      drive(1, 0, 0, 1, 0, 0, 0);
      drive(1, 1, 5, 0, 0, 0, 0);
      drive(1, 0, 0, 1, 0, 0, 15);
      // reset mid-count overrides load
      drive(1, 1, 14, 0, 0, 0, 0);
      drive(1, 0, 0, 1, 0, 0, 1);
      drive(0, 1, 5, 1, 0, 0, 1);
      drive(1, 0, 0, 1, 0, 0, 1);
      // top-of-range wrap and bottom-of-range wrap
      drive(1, 1, 15, 0, 0, 0, 0);
      drive(1, 0, 0, 1, 0, 0, 1);
      drive(1, 0, 0, 1, 1, 0, 1);
      drive(1, 0, 0, 1, 1, 1, 1);
      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         drive(($urandom_range(0, 99) >= 3),
               ($urandom_range(0, 99) < 10),
               int'($urandom_range(0, 15)),
               ($urandom_range(0, 99) < 80),
               1'($urandom),
               1'($urandom),
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15))
                                           : int'($urandom_range(0, 3)));
      end
      wait_cycles = 0;
      while (exp_q.size() > 0 && wait_cycles < 20) begin
         @(posedge clk);
         wait_cycles++;
      end
      #2;
      if (exp_q.size() != 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
